// File: rtl/approx_div_pkg.sv
// rtl/approx_div_pkg.sv - shared FSM state type and approximate-column mask helper
package approx_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Low a(t) columns are approximate, a(t) = max(0, t - (dw - p)) for p >= 2.
    function automatic logic [31:0] approx_mask(input int t, input int p, input int dw);
        int a;
        a = 0;
        if ((p >= 2) && (t > (dw - p))) begin
            a = t - (dw - p);
        end
        return (32'd1 << a) - 32'd1;
    endfunction

endpackage

// File: rtl/div_row.sv
// rtl/div_row.sv - combinational DW-column subtract/restore row with per-column cell select
module div_row #(
    parameter int DW = 8
) (
    input  logic [DW:0]   window,
    input  logic [DW-1:0] divisor,
    input  logic [DW-1:0] mask,
    output logic          qs,
    output logic [DW-1:0] r
);

    logic [DW-1:0] w_diff;
    logic          w_borrow_out;

    // Approximate cells forward their window bit and pass the divisor bit on as borrow.
    always_comb begin
        logic w_borrow;
        w_borrow = 1'b0;
        w_diff   = '0;
        for (int i = 0; i < DW; i++) begin
            if (mask[i]) begin
                w_diff[i] = window[i];
                w_borrow  = divisor[i];
            end else begin
                w_diff[i] = window[i] ^ divisor[i] ^ w_borrow;
                w_borrow  = (~window[i] & w_borrow) | (~window[i] & divisor[i])
                          | (divisor[i] & w_borrow);
            end
        end
        w_borrow_out = w_borrow;
    end

    assign qs = ~w_borrow_out | window[DW];
    assign r  = qs ? w_diff : window[DW-1:0];

endmodule

// File: rtl/approx_seq_divider.sv
// rtl/approx_seq_divider.sv - sequential restoring divider, one quotient bit per clock
module approx_seq_divider
    import approx_div_pkg::*;
#(
    parameter int DW = 8,
    parameter int PW = $clog2(DW + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    input  logic [PW-1:0]   approx_p,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_zero,
    output logic            ovf
);

    localparam int TW = (DW > 1) ? $clog2(DW) : 1;

    state_t        r_state;
    state_t        w_next_state;
    logic [DW:0]   r_window;
    logic [DW-2:0] r_low;
    logic [DW-1:0] r_divisor;
    logic [PW-1:0] r_p;
    logic [TW-1:0] r_t;
    logic [DW-1:0] r_q;
    logic          r_dz_lat;
    logic          r_ovf_lat;
    logic [DW-1:0] r_quotient;
    logic [DW-1:0] r_remainder;
    logic          r_div_zero;
    logic          r_ovf;

    logic [PW-1:0] w_p_clamped;
    logic [31:0]   w_mask_full;
    logic [DW-1:0] w_mask;
    logic          w_qs;
    logic [DW-1:0] w_r;
    logic          w_last;

    assign w_p_clamped = (int'(approx_p) > DW) ? PW'(DW) : approx_p;
    assign w_mask_full = approx_mask(int'(r_t), int'(r_p), DW);
    assign w_mask      = w_mask_full[DW-1:0];
    assign w_last      = (r_t == TW'(DW - 1));

    div_row #(.DW(DW)) u_row (
        .window  (r_window),
        .divisor (r_divisor),
        .mask    (w_mask),
        .qs      (w_qs),
        .r       (w_r)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window    <= '0;
            r_low       <= '0;
            r_divisor   <= '0;
            r_p         <= '0;
            r_t         <= '0;
            r_q         <= '0;
            r_dz_lat    <= 1'b0;
            r_ovf_lat   <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_div_zero  <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_window  <= dividend[2*DW-1:DW-1];
                        r_low     <= dividend[DW-2:0];
                        r_divisor <= divisor;
                        r_p       <= w_p_clamped;
                        r_t       <= '0;
                        r_q       <= '0;
                        r_dz_lat  <= (divisor == '0);
                        r_ovf_lat <= (dividend[2*DW-1:DW] >= divisor);
                    end
                end
                ST_RUN: begin
                    // Remaining dividend bits enter the window MSB-first from r_low.
                    r_q      <= {r_q[DW-2:0], w_qs};
                    r_window <= {w_r, r_low[DW-2]};
                    r_low    <= r_low << 1;
                    if (w_last) begin
                        r_t         <= '0;
                        r_quotient  <= {r_q[DW-2:0], w_qs};
                        r_remainder <= w_r;
                        r_div_zero  <= r_dz_lat;
                        r_ovf       <= r_ovf_lat;
                    end else begin
                        r_t <= r_t + TW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = r_quotient;
    assign remainder = r_remainder;
    assign div_zero  = r_div_zero;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_approx_seq_divider.sv
// tb/tb_approx_seq_divider.sv - randomized self-checking bench for approx_seq_divider
module tb_approx_seq_divider;

    localparam int DW = 8;
    localparam int PW = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [2*DW-1:0] dividend;
    logic [DW-1:0]   divisor;
    logic [PW-1:0]   approx_p;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;
    logic            div_zero;
    logic            ovf;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc_cnt  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    approx_seq_divider #(.DW(DW), .PW(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .approx_p  (approx_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .ovf       (ovf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Long division from the cell rules: low a(t) columns keep the window bit and
    // hand divisor bit a-1 to the exact part as its borrow-in.
    function automatic void ref_model(input logic [15:0] dd, input logic [7:0] dv, input int p_in,
                                      output logic [7:0] q, output logic [7:0] rm);
        int p, w, y, qq, r;
        p  = (p_in > 8) ? 8 : p_in;
        w  = int'(dd[15:7]);
        y  = int'(dv);
        qq = 0;
        r  = 0;
        for (int t = 0; t < 8; t++) begin
            int a, bin, hi, qs;
            a   = (p >= 2 && t > 8 - p) ? t - (8 - p) : 0;
            bin = (a > 0) ? ((y >> (a - 1)) & 1) : 0;
            hi  = ((w & 255) >> a) - (y >> a) - bin;
            qs  = (hi < 0) ? ((w >> 8) & 1) : 1;
            r   = (qs != 0) ? (((hi & ((1 << (8 - a)) - 1)) << a) | (w & ((1 << a) - 1))) : (w & 255);
            qq  = (qq << 1) | qs;
            if (t < 7) w = (r << 1) | int'(dd[6 - t]);
        end
        q  = qq[7:0];
        rm = r[7:0];
    endfunction

    task automatic run_op(input logic [15:0] dd, input logic [7:0] dv, input logic [3:0] p,
                          input int hold, input bit early,
                          output logic [7:0] q, output logic [7:0] rm, output logic dz, output logic ov);
        int n;
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        approx_p = p;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        approx_p = 4'($urandom);
        if (early) out_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 3) check("busy_in_ready", in_ready, 0);
        end while (!out_valid && n < 40);
        check("latency", n, DW + 1);
        q  = quotient;
        rm = remainder;
        dz = div_zero;
        ov = ovf;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (quotient !== q || remainder !== rm || out_valid !== 1'b1 || in_ready !== 1'b0)
                check("hold_stable", {quotient, remainder, 7'd0, out_valid, 7'd0, in_ready},
                      {q, rm, 8'd1, 8'd0});
            else
                check("hold_stable", 1, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("idle_in_ready", in_ready, 1);
        check("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  q, rm, eq, er;
        logic        dz, ov;
        logic [15:0] dd;
        logic [7:0]  dv;
        logic [3:0]  p;
        int          acc[$];
        int          seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        approx_p  = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_flags", {div_zero, ovf}, 0);
        rst = 1'b0;

        // Directed vectors; the first also holds back-pressure for 20 cycles.
        run_op(16'd100, 8'd7, 4'd0, 20, 1'b0, q, rm, dz, ov);
        check("d100_q", q, 14);
        check("d100_r", rm, 2);
        check("d100_flags", {dz, ov}, 2'b00);

        run_op(16'd1000, 8'd16, 4'd4, 0, 1'b0, q, rm, dz, ov);
        check("d1000_q", q, 62);
        check("d1000_r", rm, 8);

        run_op(16'd7, 8'd3, 4'd8, 0, 1'b1, q, rm, dz, ov);
        ref_model(16'd7, 8'd3, 8, eq, er);
        check("d7_p8_q", q, eq);
        check("d7_p8_r", rm, 7);
        check("d7_p8_differs", (q != 8'd2), 1);

        run_op(16'h1234, 8'd0, 4'd0, 0, 1'b0, q, rm, dz, ov);
        check("dz_q", q, 8'hFF);
        check("dz_r", rm, 8'h34);
        check("dz_flags", {dz, ov}, 2'b11);

        run_op(16'h0900, 8'd5, 4'd1, 0, 1'b0, q, rm, dz, ov);
        check("ovf_flags", {dz, ov}, 2'b01);

        // Back-to-back with out_ready held high: accepts DW+2 cycles apart.
        @(negedge clk);
        dividend  = 16'd500;
        divisor   = 8'd9;
        approx_p  = 4'd0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (in_valid && in_ready) acc.push_back(cyc_cnt);
            @(negedge clk);
        end
        in_valid = 1'b0;
        if (acc.size() >= 3) begin
            check("throughput_0", acc[1] - acc[0], DW + 2);
            check("throughput_1", acc[2] - acc[1], DW + 2);
        end else begin
            check("throughput_cnt", acc.size(), 3);
        end
        repeat (15) @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of RUN discards the operation.
        @(negedge clk);
        dividend = 16'd1234;
        divisor  = 8'd77;
        approx_p = 4'd0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_run_out_valid", out_valid, 0);
        check("rst_run_quotient", quotient, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_run_no_valid", seen, 0);
        check("rst_run_in_ready", in_ready, 1);

        // Random regression: exact reference for p in {0,1}, cell model otherwise.
        for (int k = 0; k < 2000; k++) begin
            int  hold;
            bit  early;
            dv = 8'($urandom);
            if ($urandom_range(0, 9) == 0) dv = 8'd0;
            dd = 16'($urandom);
            if (dv != 0 && $urandom_range(0, 1) == 1) dd[15:8] = 8'($urandom % dv);
            p     = (k < 1000) ? 4'($urandom_range(0, 1)) : 4'($urandom_range(2, 15));
            early = ($urandom_range(0, 3) == 0);
            hold  = early ? 0 : $urandom_range(0, 2);
            run_op(dd, dv, p, hold, early, q, rm, dz, ov);
            if (p <= 1 && dv != 0 && dd[15:8] < dv) begin
                eq = 8'(dd / dv);
                er = 8'(dd % dv);
            end else begin
                ref_model(dd, dv, int'(p), eq, er);
            end
            check("rand_q", q, eq);
            check("rand_r", rm, er);
            check("rand_flags", {dz, ov}, {dv == 8'd0, dd[15:8] >= dv});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
